div_unit: RTL



---
 rtl/div_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            valid,
  output logic            busy,
  output logic            stall
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [5:0]      LastIter = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic            neg_quo_q, neg_rem_q, valid_q;
  logic [5:0]      cnt_q;

  logic            is_signed, a_neg, b_neg, div_zero, overflow, early;
  logic [XLEN-1:0] mag_a, mag_b, special_res, early_res;
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] rem_nx, quo_nx, fin_quo, fin_rem, fin_res;

  always_comb begin
    is_signed   = ~op[0];
    a_neg       = is_signed & dividend[XLEN-1];
    b_neg       = is_signed & divisor[XLEN-1];
    mag_a       = a_neg ? -dividend : dividend;
    mag_b       = b_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    overflow    = is_signed & (dividend == MinNeg) & (divisor == '1);
    special_res = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : MinNeg);
`ifdef DIV_EARLY_OUT_EN
    early       = (mag_a < mag_b);
`else
    early       = 1'b0;
`endif
    // Quotient is zero, so the remainder is the original signed dividend.
    early_res   = op[1] ? dividend : '0;
  end

  // One restoring step; rem_sh needs XLEN+1 bits because 2*rem+1 can exceed XLEN bits.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, dvsr_q};
    rem_nx  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    fin_quo = neg_quo_q ? -quo_nx : quo_nx;
    fin_rem = neg_rem_q ? -rem_nx : rem_nx;
    fin_res = op_q[1] ? fin_rem : fin_quo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (start) begin
            if (div_zero || overflow) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end else if (early) begin
              result_q <= early_res;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end else begin
              op_q      <= op;
              quo_q     <= mag_a;
              dvsr_q    <= mag_b;
              rem_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= '0;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LastIter) begin
            result_q <= fin_res;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign valid  = valid_q & ~flush;
  assign busy   = (state_q != StIdle);
  // Must not depend on the operands: they arrive through the forwarding network.
  assign stall  = ((state_q == StIdle) & start & ~flush) | (state_q == StCalc);

endmodule
